// File: rtl/segway_pkg.sv
// Shared types and command codes for the Segway BLE command link.
package segway_pkg;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_synch.sv
// Two-flop synchroniser for the serial line plus an edge flop giving a falling-edge strobe.
module rx_synch (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  // All stages reset high so a reset never looks like a start edge.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[1:0], rx};
  end

  assign rx_s = sync_pipe[1];
  assign fall = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command link; decodes 'G'/'S' into a steering-enable level.
module uart_cmd_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       en_steer,
  output logic       cmd_unk
);

  localparam int            CW   = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  logic          rx_s, fall;
  rx_state_t     state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          expire;
  logic          start_det, ld_full, clr_bits, shift, byte_ok, byte_bad;

  rx_synch u_synch (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign expire = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (fall)   nxt = START;
      START: if (expire) nxt = rx_s ? IDLE : DATA;
      DATA:  if (expire && bit_cnt == 3'd7) nxt = STOP;
      STOP:  if (expire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    start_det = 1'b0;
    ld_full   = 1'b0;
    clr_bits  = 1'b0;
    shift     = 1'b0;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    unique case (state)
      IDLE:  start_det = fall;
      // A high line at mid start bit is a glitch: drop back without touching outputs.
      START: if (expire && !rx_s) begin
               ld_full  = 1'b1;
               clr_bits = 1'b1;
             end
      DATA:  if (expire) begin
               shift   = 1'b1;
               ld_full = 1'b1;
             end
      STOP:  if (expire) begin
               byte_ok  = rx_s;
               byte_bad = ~rx_s;
             end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
      en_steer <= 1'b0;
      cmd_unk  <= 1'b0;
    end else begin
      frm_err <= byte_bad;
      cmd_unk <= 1'b0;

      if (start_det)     cnt <= HALF;
      else if (ld_full)  cnt <= FULL;
      else if (cnt != 0) cnt <= cnt - CW'(1);

      if (clr_bits)   bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (shift) shreg <= {rx_s, shreg[7:1]};

      if (byte_ok) begin
        rx_data <= shreg;
        rdy     <= 1'b1;
        if (shreg == CMD_GO)        en_steer <= 1'b1;
        else if (shreg == CMD_STOP) en_steer <= 1'b0;
        else                        cmd_unk  <= 1'b1;
      end else if (start_det || clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule
